// File: rtl/gray_step_decoder_pkg.sv
// Shared types and constants for the Gray-code step decoder.
// GRAY_SYNC_EN selects the synchronised-input variant (longer warm-up).
package gray_step_pkg;

  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] DIFF_NONE = 3'd0;
  localparam logic [CODE_W-1:0] DIFF_UP   = 3'd1;
  localparam logic [CODE_W-1:0] DIFF_DN   = 3'd7;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    ERROR    = 2'd2
  } state_t;

  // Warm-up must cover every input register stage before the first compare
`ifdef GRAY_SYNC_EN
  localparam int UNLOCK_CYC = 3;
`else
  localparam int UNLOCK_CYC = 1;
`endif

  localparam logic [1:0] UNLOCK_LAST = 2'(UNLOCK_CYC - 1);

endpackage

// File: rtl/gray_step_decoder_if.sv
// Bundle between the Gray-code source side and the step decoder.
// master drives the code and clear; slave (the decoder) returns the status.
interface gray_step_decoder_if #(
  parameter int POS_W = 8
);

  logic             clear;
  logic [2:0]       gray_in;
  logic [2:0]       code_bin;
  logic [POS_W-1:0] pos;
  logic             step_up;
  logic             step_dn;
  logic             err;
  logic             err_sticky;
  logic             locked;

  modport master (
    output clear,
    output gray_in,
    input  code_bin,
    input  pos,
    input  step_up,
    input  step_dn,
    input  err,
    input  err_sticky,
    input  locked
  );

  modport slave (
    input  clear,
    input  gray_in,
    output code_bin,
    output pos,
    output step_up,
    output step_dn,
    output err,
    output err_sticky,
    output locked
  );

endinterface

// File: rtl/gray_step_decoder_gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray_to_bin
  import gray_step_pkg::*;
#(
  parameter int W = CODE_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Running XOR from the MSB down
  always_comb begin
    bin        = {W{1'b0}};
    bin[W-1]   = gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_step_decoder.sv
// Gray-code step decoder: classifies each sampled code change as +1/-1/none/illegal
// and tracks a wrapping position. Build option: GRAY_SYNC_EN adds a 2-flop input synchroniser.
module gray_step_decoder
  import gray_step_pkg::*;
#(
  parameter int               POS_W     = 8,
  parameter logic [POS_W-1:0] START_POS = {POS_W{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset,
  gray_step_decoder_if.slave   bus
);

  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

`ifdef GRAY_SYNC_EN
  logic [CODE_W-1:0] sync1_r;
  logic [CODE_W-1:0] sync2_r;
`endif

  logic [CODE_W-1:0] gray_q_r;
  logic [CODE_W-1:0] prev_bin_r;
  logic [CODE_W-1:0] code_bin_r;
  logic [CODE_W-1:0] cur_bin_s;
  logic [CODE_W-1:0] diff_s;
  logic [POS_W-1:0]  pos_r;
  logic [1:0]        unlock_cnt_r;
  logic              step_up_r;
  logic              step_dn_r;
  logic              err_r;
  logic              err_sticky_r;
  logic              locked_r;
  state_t            state_r;

  gray_to_bin #(
    .W (CODE_W)
  ) u_gray_to_bin (
    .gray (gray_q_r),
    .bin  (cur_bin_s)
  );

  // Modulo-8 distance between consecutive samples
  always_comb begin
    diff_s = cur_bin_s - prev_bin_r;
  end

  // Input pipeline, position accumulator, pulse outputs and lock FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
`ifdef GRAY_SYNC_EN
      sync1_r      <= 3'd0;
      sync2_r      <= 3'd0;
`endif
      gray_q_r     <= 3'd0;
      prev_bin_r   <= 3'd0;
      code_bin_r   <= 3'd0;
      pos_r        <= START_POS;
      unlock_cnt_r <= 2'd0;
      step_up_r    <= 1'b0;
      step_dn_r    <= 1'b0;
      err_r        <= 1'b0;
      err_sticky_r <= 1'b0;
      locked_r     <= 1'b0;
      state_r      <= UNLOCKED;
    end else begin
`ifdef GRAY_SYNC_EN
      sync1_r      <= bus.gray_in;
      sync2_r      <= sync1_r;
      gray_q_r     <= sync2_r;
`else
      gray_q_r     <= bus.gray_in;
`endif
      // Sample history keeps tracking through clear so re-lock sees no false step
      prev_bin_r   <= cur_bin_s;
      code_bin_r   <= cur_bin_s;
      step_up_r    <= 1'b0;
      step_dn_r    <= 1'b0;
      err_r        <= 1'b0;

      if (bus.clear) begin
        pos_r        <= START_POS;
        unlock_cnt_r <= 2'd0;
        err_sticky_r <= 1'b0;
        locked_r     <= 1'b0;
        state_r      <= UNLOCKED;
      end else begin
        case (state_r)
          UNLOCKED: begin
            if (unlock_cnt_r == UNLOCK_LAST) begin
              unlock_cnt_r <= 2'd0;
              locked_r     <= 1'b1;
              state_r      <= LOCKED;
            end else begin
              unlock_cnt_r <= unlock_cnt_r + 2'd1;
              locked_r     <= 1'b0;
            end
          end
          LOCKED: begin
            case (diff_s)
              DIFF_NONE: begin
                locked_r <= 1'b1;
              end
              DIFF_UP: begin
                step_up_r <= 1'b1;
                pos_r     <= pos_r + POS_ONE;
                locked_r  <= 1'b1;
              end
              DIFF_DN: begin
                step_dn_r <= 1'b1;
                pos_r     <= pos_r - POS_ONE;
                locked_r  <= 1'b1;
              end
              default: begin
                err_r        <= 1'b1;
                err_sticky_r <= 1'b1;
                locked_r     <= 1'b0;
                state_r      <= ERROR;
              end
            endcase
          end
          ERROR: begin
            locked_r <= 1'b0;
          end
          default: begin
            unlock_cnt_r <= 2'd0;
            locked_r     <= 1'b0;
            state_r      <= UNLOCKED;
          end
        endcase
      end
    end
  end

  assign bus.code_bin   = code_bin_r;
  assign bus.pos        = pos_r;
  assign bus.step_up    = step_up_r;
  assign bus.step_dn    = step_dn_r;
  assign bus.err        = err_r;
  assign bus.err_sticky = err_sticky_r;
  assign bus.locked     = locked_r;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Scoreboard bench for gray_step_decoder: directed and random Gray sequences
// against a sample-history reference model.
module tb_gray_step_decoder;

  localparam int               POS_W     = 3;
  localparam int               POS_MOD   = 1 << POS_W;
  localparam logic [POS_W-1:0] START_POS = 3'd2;
`ifdef GRAY_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam logic [2:0] GSEQ [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                      3'b110, 3'b111, 3'b101, 3'b100};

  typedef struct packed {
    logic [2:0]       code_bin;
    logic [POS_W-1:0] pos;
    logic             up;
    logic             dn;
    logic             err;
    logic             sticky;
    logic             locked;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  gray_step_decoder_if #(.POS_W(POS_W)) bus();

  gray_step_decoder #(
    .POS_W     (POS_W),
    .START_POS (START_POS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: binary codes presented before each edge since reset
  int   in_bin[$];
  int   m_pos;
  int   m_mode;    // 0 warming up, 1 tracking, 2 halted on error
  int   m_wait;
  bit   m_sticky;
  int   cb;

  function automatic int g2b(logic [2:0] g);
    for (int i = 0; i < 8; i++) begin
      if (GSEQ[i] == g) return i;
    end
    return 0;
  endfunction

  function automatic int seen(int k);
    if (k < 1) return 0;
    return in_bin[k-1];
  endfunction

  task automatic model_reset();
    in_bin.delete();
    m_pos    = int'(START_POS);
    m_mode   = 0;
    m_wait   = LAT;
    m_sticky = 1'b0;
    cb       = 0;
  endtask

  // Called at a falling edge: apply inputs, predict the next rising edge, advance.
  task automatic drive(input int b, input bit clr);
    int   n, cur, prv, d;
    exp_t e;
    b           = b % 8;
    cb          = b;
    bus.gray_in = GSEQ[b];
    bus.clear   = clr;
    in_bin.push_back(g2b(GSEQ[b]));
    n   = in_bin.size();
    cur = seen(n - LAT);
    prv = seen(n - LAT - 1);
    e   = '0;
    if (clr) begin
      m_pos    = int'(START_POS);
      m_sticky = 1'b0;
      m_mode   = 0;
      m_wait   = LAT;
    end else if (m_mode == 0) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      d = (cur - prv + 8) % 8;
      if (d == 1) begin
        e.up  = 1'b1;
        m_pos = (m_pos + 1) % POS_MOD;
      end else if (d == 7) begin
        e.dn  = 1'b1;
        m_pos = (m_pos + POS_MOD - 1) % POS_MOD;
      end else if (d != 0) begin
        e.err    = 1'b1;
        m_sticky = 1'b1;
        m_mode   = 2;
      end
    end
    e.code_bin = 3'(cur);
    e.pos      = POS_W'(m_pos);
    e.sticky   = m_sticky;
    e.locked   = (m_mode == 1);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  exp_t mon_e;
  exp_t mon_a;

  // Monitor: one output sample per rising edge while out of reset
  always @(posedge clk) begin
    #1;
    if (reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {bus.code_bin, bus.pos, bus.step_up, bus.step_dn,
               bus.err, bus.err_sticky, bus.locked};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL outputs t=%0t got code=%0d pos=%0d up=%0b dn=%0b err=%0b st=%0b lk=%0b want code=%0d pos=%0d up=%0b dn=%0b err=%0b st=%0b lk=%0b",
                 $time, mon_a.code_bin, mon_a.pos, mon_a.up, mon_a.dn, mon_a.err,
                 mon_a.sticky, mon_a.locked, mon_e.code_bin, mon_e.pos, mon_e.up,
                 mon_e.dn, mon_e.err, mon_e.sticky, mon_e.locked);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    checks++;
    if (bus.code_bin !== 3'd0 || bus.pos !== START_POS || bus.step_up !== 1'b0 ||
        bus.step_dn !== 1'b0 || bus.err !== 1'b0 || bus.err_sticky !== 1'b0 ||
        bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL %s got code=%0d pos=%0d up=%0b dn=%0b err=%0b st=%0b lk=%0b want code=0 pos=%0d others=0",
               tag, bus.code_bin, bus.pos, bus.step_up, bus.step_dn, bus.err,
               bus.err_sticky, bus.locked, START_POS);
    end
  endtask

  initial begin
    int r, nb;
    bit clr;
    bus.gray_in = 3'b000;
    bus.clear   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset_state");
    reset = 1'b1;

    // Settle and lock on code 0
    repeat (3) drive(0, 1'b0);
    // Up sequence 000,001,011,010,110
    for (int i = 1; i <= 4; i++) drive(i, 1'b0);
    drive(4, 1'b0);
    // Walk down through the position wrap 0 -> max, then back up across it
    for (int i = 0; i < 7; i++) drive(cb + 7, 1'b0);
    drive(cb + 1, 1'b0);
    drive(cb + 1, 1'b0);
    // Illegal jump of +3, then legal steps that must be ignored
    drive(cb + 3, 1'b0);
    for (int i = 0; i < 4; i++) drive(cb + 1, 1'b0);
    // Clear coincident with a legal step, then steps after re-lock
    drive(cb + 1, 1'b1);
    for (int i = 0; i < 5; i++) drive(cb + 1, 1'b0);
    for (int i = 0; i < 3; i++) drive(cb + 7, 1'b0);

    // Randomised walk with occasional illegal jumps and clears
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 99);
      clr = (r < 5);
      if (r >= 5 && r < 9)       nb = cb + $urandom_range(2, 6);
      else if (r < 45)           nb = cb + 1;
      else if (r < 80)           nb = cb + 7;
      else                       nb = cb;
      drive(nb, clr);
    end

    // Mid-count asynchronous reset
    drive(cb, 1'b1);
    for (int i = 0; i < LAT + 4; i++) drive(cb + 1, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    bus.gray_in = 3'b000;
    bus.clear   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_hold");
    reset = 1'b1;
    model_reset();
    repeat (LAT + 1) drive(0, 1'b0);
    for (int i = 0; i < 6; i++) drive(cb + 1, 1'b0);
    for (int i = 0; i < 4; i++) drive(cb + 7, 1'b0);

    // Drain the scoreboard within a bounded number of edges
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
